// File: rtl/count_pkg.sv
package count_pkg;

  typedef logic [7:0] count_t;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    SYNC,
    LOCKED
  } checker_state_t;

  // The upstream counter steps on both clock edges, so posedge-only sampling sees +2.
  localparam int unsigned COUNT_STEP_DUAL_EDGE = 2;

endpackage

// File: rtl/sample_fifo2.sv
module sample_fifo2
  import count_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  count_t push_data,
  input  logic   out_ready,
  output logic   out_valid,
  output count_t out_data,
  output logic   overflow
);

  count_t     head_q, head_d;
  count_t     tail_q, tail_d;
  logic [1:0] count_q, count_d;
  logic       ovf_q, ovf_d;
  logic       pop;

  assign pop = (count_q != 2'd0) && out_ready;

  // Head is a register rather than a read port, so it keeps the last head value once empty.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = push_data;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = push_data;
        end else if (push) begin
          tail_d  = push_data;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d = tail_q;
          if (push) begin
            tail_d = push_data;
          end else begin
            count_d = 2'd1;
          end
        end else if (push) begin
          ovf_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign overflow  = ovf_q;

endmodule

// File: rtl/count_checker.sv
module count_checker
  import count_pkg::*;
#(
  parameter int unsigned STEP       = COUNT_STEP_DUAL_EDGE,
  parameter int unsigned LOCK_COUNT = 3,
  parameter int unsigned ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [7:0]       in,
  output logic             locked,
  output logic             error,
  output logic [ERR_W-1:0] errCount,
  output logic [7:0]       expected,
  output logic             outValid,
  output logic [7:0]       outData,
  input  logic             outReady,
  output logic             overflow
);

  localparam count_t     STEP_C = count_t'(STEP);
  localparam logic [3:0] LOCK_C = 4'(LOCK_COUNT);

  checker_state_t   state_q, state_d;
  count_t           expected_q, expected_d;
  logic [3:0]       match_q, match_d;
  logic             locked_q, locked_d;
  logic             error_q, error_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  count_t     next_exp;
  logic [3:0] match_inc;
  logic       sample_ok;
  logic       push;

  assign next_exp  = in + STEP_C;
  assign match_inc = match_q + 4'd1;
  assign sample_ok = (in == expected_q);

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    match_d     = match_q;
    locked_d    = locked_q;
    error_d     = 1'b0;
    err_count_d = err_count_q;
    push        = 1'b0;
    if (!enable) begin
      state_d  = IDLE;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ACQUIRE;
        end
        ACQUIRE: begin
          expected_d = next_exp;
          match_d    = '0;
          state_d    = SYNC;
        end
        SYNC: begin
          expected_d = next_exp;
          if (sample_ok) begin
            match_d = match_inc;
            if (match_inc == LOCK_C) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          expected_d = next_exp;
          if (sample_ok) begin
            push = 1'b1;
          end else begin
            error_d = 1'b1;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + ERR_W'(1);
            end
            match_d  = '0;
            locked_d = 1'b0;
            state_d  = SYNC;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      expected_q  <= '0;
      match_q     <= '0;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      match_q     <= match_d;
      locked_q    <= locked_d;
      error_q     <= error_d;
      err_count_q <= err_count_d;
    end
  end

  sample_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in),
    .out_ready (outReady),
    .out_valid (outValid),
    .out_data  (outData),
    .overflow  (overflow)
  );

  assign locked   = locked_q;
  assign error    = error_q;
  assign errCount = err_count_q;
  assign expected = expected_q;

endmodule
